// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-beat-per-word line fill.
// Ports: fetch_ic_* request in, icache_* response out, icache_mem_*/mem_* fill side.
module icache #(
   parameter int SETS  = 64,
   parameter int WORDS = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fetch_ic_req,
   input  logic [29:0]                   fetch_ic_addr,
   input  logic                          fetch_ic_flush,
   output logic                          icache_ready,
   output logic                          icache_valid,
   output logic                          icache_error,
   output logic [31:0]                   icache_data,
   output logic                          icache_mem_req,
   output logic [29-$clog2(WORDS):0]     icache_mem_addr,
   input  logic                          mem_ready,
   input  logic                          mem_valid,
   input  logic                          mem_error,
   input  logic [31:0]                   mem_data
);

   localparam int IB = $clog2(SETS);
   localparam int OB = $clog2(WORDS);
   localparam int TW = 30 - IB - OB;

   typedef enum logic [2:0] {IDLE, LOOKUP, MEMREQ, FILL, RESP} state_t;

   state_t           state_q, state_d;
   logic [29:0]      addr_q;
   logic [OB-1:0]    cnt_q;
   logic             err_q;
   logic             cancel_q;
   logic [SETS-1:0]  vld_q;
   logic [TW-1:0]    tag_ram  [SETS];
   logic [31:0]      data_ram [SETS*WORDS];

   logic [IB-1:0]    idx;
   logic [OB-1:0]    off;
   logic [TW-1:0]    tag;
   logic             hit;
   logic             beat;
   logic             last;
   logic             drop;

   assign idx  = addr_q[IB+OB-1:OB];
   assign off  = addr_q[OB-1:0];
   assign tag  = addr_q[29:IB+OB];
   assign hit  = vld_q[idx] && (tag_ram[idx] == tag);
   assign beat = (state_q == FILL) && mem_valid;
   assign last = beat && (&cnt_q);
   // a flush seen at any point of the miss suppresses the response
   assign drop = cancel_q || fetch_ic_flush;

   assign icache_mem_addr = addr_q[29:OB];

   always_comb begin
      state_d        = state_q;
      icache_ready   = 1'b0;
      icache_valid   = 1'b0;
      icache_error   = 1'b0;
      icache_mem_req = 1'b0;
      unique case (state_q)
         IDLE: icache_ready = 1'b1;
         LOOKUP: begin
            if (hit) begin
               icache_valid = 1'b1;
               icache_ready = 1'b1;
               state_d      = IDLE;
            end else begin
               state_d = MEMREQ;
            end
         end
         MEMREQ: begin
            icache_mem_req = 1'b1;
            if (mem_ready) state_d = FILL;
         end
         FILL: begin
            if (last) state_d = drop ? IDLE : RESP;
         end
         RESP: begin
            icache_valid = 1'b1;
            icache_error = err_q;
            icache_ready = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (fetch_ic_flush) begin
         icache_valid = 1'b0;
         icache_error = 1'b0;
         icache_ready = 1'b0;
         if (state_q == LOOKUP || state_q == RESP) state_d = IDLE;
      end
      if (fetch_ic_req && icache_ready) state_d = LOOKUP;
   end

   // data is forced to zero unless a good word is returned
   assign icache_data = (icache_valid && !icache_error) ?
                        data_ram[{idx, off}] : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         cancel_q <= 1'b0;
         vld_q    <= '0;
      end else begin
         state_q <= state_d;
         if (fetch_ic_req && icache_ready) addr_q <= fetch_ic_addr;
         if (fetch_ic_flush && (state_q == MEMREQ || state_q == FILL))
            cancel_q <= 1'b1;
         if (state_q == RESP) err_q <= 1'b0;
         if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            // line stays invalid while it is partly overwritten
            vld_q[idx] <= last && !err_q && !mem_error;
            if (last && drop) err_q <= 1'b0;
            else if (mem_error) err_q <= 1'b1;
            if (last) cancel_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (beat) data_ram[{idx, cnt_q}] <= mem_data;
      if (last) tag_ram[idx] <= tag;
   end

endmodule
